pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
// - Sequences the Gowin rPLL: drives its RESET, watches its LOCK and gates release of system reset.
// - Runs on the 27 MHz PLL input clock (clkin), so it is never clocked by the PLL output it controls.
// - Retries a failed lock a bounded number of times, then raises a sticky fault.
// - sys_rst_n is in the clkin domain; each consumer domain re-synchronises it.
// PARAMETERS
// RESET_CYCLES   16    clkin cycles pll_reset is held high per attempt (>=1)
// LOCK_TIMEOUT   2700  clkin cycles allowed from pll_reset fall to lock (~100 us)
// LOCK_STABLE    256   consecutive synchronised-lock cycles required before release
// MAX_RETRIES    3     re-attempts after the first; retry_count width = $clog2(MAX_RETRIES+1)
// SYNC_STAGES    2     flops on the pll_lock synchroniser (>=2)
// PORTS
// clkin        in   1   27 MHz reference clock, same net feeding the PLL CLKIN
// rst_n        in   1   asynchronous, active-low reset
// pll_lock     in   1   PLL LOCK output, asynchronous to clkin
// relock_req   in   1   single-cycle request to re-run the sequence from scratch
// pll_reset    out  1   to PLL RESET, active high
// pll_ready    out  1   PLL locked and stable (state RUN)
// sys_rst_n    out  1   system reset release, active low, deasserted only in RUN
// lock_lost    out  1   one-cycle pulse when lock drops while in RUN
// fault        out  1   sticky: retries exhausted
// retry_count  out  W   retries consumed in current sequence
// BEHAVIOUR
// - rst_n low (async): state=RESET, cnt=0, retry_count=0, sync flops=0.
//   Outputs: pll_reset=1, pll_ready=0, sys_rst_n=0, lock_lost=0, fault=0.
// - All outputs are registered and update in the same edge as the state; no combinational paths from inputs to outputs.
// - lock_s is pll_lock after SYNC_STAGES flops. Only lock_s is used internally.
// - RESET: pll_reset=1; cnt counts 0..RESET_CYCLES-1, then ->WAIT_LOCK with cnt=0. Exactly RESET_CYCLES cycles high.
// - WAIT_LOCK: pll_reset=0; cnt++ each cycle. lock_s=1 ->STABLE with cnt=0.
//   On cnt==LOCK_TIMEOUT-1 with lock_s=0: retry path.
// - STABLE: cnt++ while lock_s=1. cnt==LOCK_STABLE-1 ->RUN. lock_s=0 at any cycle: retry path.
// - Retry path: if retry_count==MAX_RETRIES ->FAULT. Otherwise retry_count++ and ->RESET, cnt=0.
// - RUN: pll_ready=1, sys_rst_n=1. lock_s=0 -> lock_lost=1 for one cycle, pll_ready=0, sys_rst_n=0,
//   retry_count=0, ->RESET. Worst case: SYNC_STAGES+1 clkin cycles from the pll_lock fall.
// - FAULT: fault=1, pll_reset=0, sys_rst_n=0. Exits only via relock_req or rst_n.
// - relock_req, any state: ->RESET, cnt=0, retry_count=0, fault=0.
//   If already in RESET, the RESET_CYCLES count restarts.
// - Priority: rst_n > relock_req > lock/timeout transitions.
//   lock_s rising on the timeout cycle counts as lock, not timeout.
// - Counters saturate-free: sized $clog2(max(RESET_CYCLES,LOCK_TIMEOUT,LOCK_STABLE)). One shared cnt, cleared on every state change.
// - Latency, clean lock: sys_rst_n rises SYNC_STAGES+LOCK_STABLE+1 cycles after pll_lock rises.
// STRUCTURE
// - pll_seq_pkg: state encoding (RESET, WAIT_LOCK, STABLE, RUN, FAULT; one-hot localparams)
//   and the counter-width function.
// - Sub-module sync_ff_chain (parametrised SYNC_STAGES, async active-low clear) for pll_lock.
// - Rest is one FSM plus counter; no other hierarchy.
// TESTING
// Bench params: RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2, SYNC_STAGES=2.
// 1. Clean lock: release rst_n; pll_lock rises 10 cycles after pll_reset falls.
//    -> pll_reset high exactly 4 cycles; sys_rst_n/pll_ready rise 11 cycles after pll_lock; retry_count=0.
// 2. No lock: pll_lock held 0 -> three 4-cycle pll_reset pulses, 24 cycles apart.
//    -> retry_count 0,1,2; fault=1 after cycle 72; pll_reset stays 0.
// 3. Glitch: pll_lock drops 1 cycle at STABLE cnt=5.
//    -> retry_count=1, new 4-cycle pll_reset pulse; sys_rst_n never rose.
// 4. Loss in RUN: pll_lock falls.
//    -> lock_lost 1-cycle pulse and sys_rst_n=0 within 3 cycles, retry_count=0, full resequence to RUN.
// 5. relock_req in FAULT -> fault=0 next cycle, retry_count=0, 4-cycle pll_reset pulse.
//    relock_req in RUN -> sys_rst_n=0 next cycle.
// 6. rst_n asserted mid-WAIT_LOCK (off-edge) -> all outputs at reset values immediately, no clock needed.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - State encoding and sizing helpers for the PLL lock sequencer
package pll_seq_pkg;

   localparam logic [4:0] ONEHOT_RESET     = 5'b00001;
   localparam logic [4:0] ONEHOT_WAIT_LOCK = 5'b00010;
   localparam logic [4:0] ONEHOT_STABLE    = 5'b00100;
   localparam logic [4:0] ONEHOT_RUN       = 5'b01000;
   localparam logic [4:0] ONEHOT_FAULT     = 5'b10000;

   typedef enum logic [4:0] {
      ST_RESET     = ONEHOT_RESET,
      ST_WAIT_LOCK = ONEHOT_WAIT_LOCK,
      ST_STABLE    = ONEHOT_STABLE,
      ST_RUN       = ONEHOT_RUN,
      ST_FAULT     = ONEHOT_FAULT
   } pll_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

   // The shared counter only ever has to reach (longest interval - 1).
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = max3(a, b, c);
      return (m > 2) ? $clog2(m) : 1;
   endfunction

   function automatic int retry_width(input int max_retries);
      return (max_retries > 0) ? $clog2(max_retries + 1) : 1;
   endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// rtl/sync_ff_chain.sv - Multi-flop synchroniser with asynchronous active-low clear
module sync_ff_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - Drives rPLL RESET, qualifies LOCK and gates system reset release
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RESET_CYCLES = 16,
   parameter int LOCK_TIMEOUT = 2700,
   parameter int LOCK_STABLE  = 256,
   parameter int MAX_RETRIES  = 3,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                                  clkin,
   input  logic                                  rst_n,
   input  logic                                  pll_lock,
   input  logic                                  relock_req,
   output logic                                  pll_reset,
   output logic                                  pll_ready,
   output logic                                  sys_rst_n,
   output logic                                  lock_lost,
   output logic                                  fault,
   output logic [retry_width(MAX_RETRIES)-1:0]   retry_count
);

   localparam int CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
   localparam int RW = retry_width(MAX_RETRIES);

   logic          lock_s;
   pll_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          pll_reset_q, pll_reset_d;
   logic          pll_ready_q, pll_ready_d;
   logic          sys_rst_n_q, sys_rst_n_d;
   logic          lock_lost_q, lock_lost_d;
   logic          fault_q, fault_d;
   logic          retry_path;

   sync_ff_chain #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk   (clkin),
      .rst_n (rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      retry_d     = retry_q;
      lock_lost_d = 1'b0;
      retry_path  = 1'b0;

      if (relock_req) begin
         state_d = ST_RESET;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_RESET: begin
               if (cnt_q == CW'(RESET_CYCLES - 1)) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end
            end
            // A lock seen on the timeout cycle still wins over the timeout.
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                  retry_path = 1'b1;
               end
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  retry_path = 1'b1;
               end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end
            ST_RUN: begin
               cnt_d = '0;
               if (!lock_s) begin
                  state_d     = ST_RESET;
                  retry_d     = '0;
                  lock_lost_d = 1'b1;
               end
            end
            ST_FAULT: begin
               cnt_d = '0;
            end
            default: begin
               state_d = ST_RESET;
               cnt_d   = '0;
               retry_d = '0;
            end
         endcase

         if (retry_path) begin
            cnt_d = '0;
            if (retry_q == RW'(MAX_RETRIES)) begin
               state_d = ST_FAULT;
            end else begin
               state_d = ST_RESET;
               retry_d = retry_q + 1'b1;
            end
         end
      end

      // Outputs follow the next state so they register on the same edge as it.
      pll_reset_d = (state_d == ST_RESET);
      pll_ready_d = (state_d == ST_RUN);
      sys_rst_n_d = (state_d == ST_RUN);
      fault_d     = (state_d == ST_FAULT);
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RESET;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_reset_q <= 1'b1;
         pll_ready_q <= 1'b0;
         sys_rst_n_q <= 1'b0;
         lock_lost_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_reset_q <= pll_reset_d;
         pll_ready_q <= pll_ready_d;
         sys_rst_n_q <= sys_rst_n_d;
         lock_lost_q <= lock_lost_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_reset   = pll_reset_q;
   assign pll_ready   = pll_ready_q;
   assign sys_rst_n   = sys_rst_n_q;
   assign lock_lost   = lock_lost_q;
   assign fault       = fault_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - Scoreboard bench for pll_lock_sequencer against a window-based reference model
module tb_pll_lock_sequencer;

   localparam int RESET_CYCLES = 4;
   localparam int LOCK_TIMEOUT = 20;
   localparam int LOCK_STABLE  = 8;
   localparam int MAX_RETRIES  = 2;
   localparam int SYNC_STAGES  = 2;
   localparam int MAXN         = 256;

   localparam int P_RESET  = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_RUN    = 3;
   localparam int P_FAULT  = 4;

   localparam logic [6:0] RST_VEC = 7'b1000000;

   typedef struct {
      int         edge_no;
      logic [6:0] vec;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       relock_req;
   logic       pll_reset;
   logic       pll_ready;
   logic       sys_rst_n;
   logic       lock_lost;
   logic       fault;
   logic [1:0] retry_count;

   bit         lk [0:MAXN-1];
   bit         rq [0:MAXN-1];
   logic [6:0] exp_v [0:MAXN];
   ev_t        exp_q [$];

   int         total;
   int         bad;
   int         edge_n;
   bit         active;
   logic [6:0] last_vec;

   pll_lock_sequencer #(
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .LOCK_STABLE  (LOCK_STABLE),
      .MAX_RETRIES  (MAX_RETRIES),
      .SYNC_STAGES  (SYNC_STAGES)
   ) dut (
      .clkin       (clk),
      .rst_n       (rst_n),
      .pll_lock    (pll_lock),
      .relock_req  (relock_req),
      .pll_reset   (pll_reset),
      .pll_ready   (pll_ready),
      .sys_rst_n   (sys_rst_n),
      .lock_lost   (lock_lost),
      .fault       (fault),
      .retry_count (retry_count)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dut_vec();
      return {pll_reset, pll_ready, sys_rst_n, lock_lost, fault, retry_count};
   endfunction

   function automatic logic [6:0] mk(input bit prst, input bit rdy, input bit lost, input bit flt, input int rc);
      logic [1:0] r;
      r = rc[1:0];
      return {prst, rdy, rdy, lost, flt, r};
   endfunction

   // Input driven after edge k is seen by the FSM as synchronised lock at edge k+3.
   function automatic bit ls(input int e);
      if (e >= 3) return lk[e-3];
      return 1'b0;
   endfunction

   function automatic bit rqs(input int e);
      if (e >= 1) return rq[e-1];
      return 1'b0;
   endfunction

   task automatic retry_outcome(inout int rc, output int nph, output logic [6:0] entry);
      if (rc == MAX_RETRIES) begin
         nph   = P_FAULT;
         entry = mk(0, 0, 0, 1, rc);
      end else begin
         rc    = rc + 1;
         nph   = P_RESET;
         entry = mk(1, 0, 0, 0, rc);
      end
   endtask

   // Each phase is a window measured from its entry edge; the first qualifying edge ends it.
   task automatic build_model(input int n);
      int         e, x, ph, nph, rc;
      bit         done;
      logic [6:0] steady, entry;
      ev_t        ev;
      exp_v[0] = RST_VEC;
      e  = 0;
      ph = P_RESET;
      rc = 0;
      while (e < n) begin
         case (ph)
            P_RESET: steady = mk(1, 0, 0, 0, rc);
            P_RUN:   steady = mk(0, 1, 0, 0, rc);
            P_FAULT: steady = mk(0, 0, 0, 1, rc);
            default: steady = mk(0, 0, 0, 0, rc);
         endcase
         done  = 1'b0;
         nph   = ph;
         entry = steady;
         x     = e;
         while (!done && x < n) begin
            x = x + 1;
            if (rqs(x)) begin
               rc = 0; nph = P_RESET; entry = mk(1, 0, 0, 0, 0); done = 1'b1;
            end else begin
               case (ph)
                  P_RESET: if (x == e + RESET_CYCLES) begin
                     nph = P_WAIT; entry = mk(0, 0, 0, 0, rc); done = 1'b1;
                  end
                  P_WAIT: if (ls(x)) begin
                     nph = P_STABLE; entry = mk(0, 0, 0, 0, rc); done = 1'b1;
                  end else if (x == e + LOCK_TIMEOUT) begin
                     retry_outcome(rc, nph, entry); done = 1'b1;
                  end
                  P_STABLE: if (!ls(x)) begin
                     retry_outcome(rc, nph, entry); done = 1'b1;
                  end else if (x == e + LOCK_STABLE) begin
                     nph = P_RUN; entry = mk(0, 1, 0, 0, rc); done = 1'b1;
                  end
                  P_RUN: if (!ls(x)) begin
                     rc = 0; nph = P_RESET; entry = mk(1, 0, 1, 0, 0); done = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         if (done) begin
            for (int y = e + 1; y < x; y++) exp_v[y] = steady;
            exp_v[x] = entry;
            e  = x;
            ph = nph;
         end else begin
            for (int y = e + 1; y <= n; y++) exp_v[y] = steady;
            e = n;
         end
      end
      for (int y = 1; y <= n; y++) begin
         if (exp_v[y] != exp_v[y-1]) begin
            ev.edge_no = y;
            ev.vec     = exp_v[y];
            exp_q.push_back(ev);
         end
      end
   endtask

   task automatic monitor();
      logic [6:0] cur;
      ev_t        ev;
      forever begin
         @(posedge clk);
         if (active) edge_n = edge_n + 1;
         else        edge_n = 0;
         @(negedge clk);
         cur = dut_vec();
         if (!active) begin
            last_vec = RST_VEC;
         end else if (cur !== last_vec) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
               bad = bad + 1;
               $display("FAIL unexpected_change: edge %0d got %b, required no change from %b", edge_n, cur, last_vec);
            end else begin
               ev = exp_q.pop_front();
               if (ev.edge_no != edge_n || ev.vec !== cur) begin
                  bad = bad + 1;
                  $display("FAIL event: got edge %0d vec %b, required edge %0d vec %b", edge_n, cur, ev.edge_no, ev.vec);
               end
            end
            last_vec = cur;
         end
      end
   endtask

   task automatic clear_stim();
      for (int k = 0; k < MAXN; k++) begin
         lk[k] = 1'b0;
         rq[k] = 1'b0;
      end
   endtask

   task automatic gen_random(output int n);
      int k, len;
      bit v;
      n = $urandom_range(40, 200);
      k = 0;
      v = ($urandom_range(0, 1) == 1);
      while (k < n) begin
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
         for (int j = 0; j < len && k < n; j++) begin
            lk[k] = v;
            rq[k] = ($urandom_range(0, 79) == 0);
            k = k + 1;
         end
         v = !v;
      end
   endtask

   task automatic run_scenario(input int n);
      int r;
      build_model(n);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      active = 1'b1;
      for (int k = 0; k < n; k++) begin
         pll_lock   = lk[k];
         relock_req = rq[k];
         @(negedge clk);
      end
      #1;
      active = 1'b0;
      total  = total + 1;
      if (exp_q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
      end
      exp_q.delete();
      pll_lock   = 1'b0;
      relock_req = 1'b0;
      r = $urandom_range(1, 2);
      #(r);
      rst_n = 1'b0;
      #1;
      total = total + 1;
      if (dut_vec() !== RST_VEC) begin
         bad = bad + 1;
         $display("FAIL async_rst: got %b, required %b", dut_vec(), RST_VEC);
      end
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      pll_lock   = 1'b0;
      relock_req = 1'b0;
      active     = 1'b0;
      total      = 0;
      bad        = 0;
      edge_n     = 0;
      last_vec   = RST_VEC;
      fork
         monitor();
      join_none

      repeat (2) @(negedge clk);
      total = total + 1;
      if (dut_vec() !== RST_VEC) begin
         bad = bad + 1;
         $display("FAIL reset_state: got %b, required %b", dut_vec(), RST_VEC);
      end

      // Clean lock 10 cycles after pll_reset falls.
      clear_stim();
      for (int k = 14; k < MAXN; k++) lk[k] = 1'b1;
      run_scenario(40);

      // No lock: three attempts then fault.
      clear_stim();
      run_scenario(90);

      // One-cycle glitch while in STABLE.
      clear_stim();
      for (int k = 14; k < MAXN; k++) lk[k] = 1'b1;
      lk[20] = 1'b0;
      run_scenario(60);

      // Loss in RUN then full resequence.
      clear_stim();
      for (int k = 14; k < MAXN; k++) lk[k] = 1'b1;
      for (int k = 30; k < 34; k++) lk[k] = 1'b0;
      run_scenario(60);

      // relock_req out of FAULT, then lock.
      clear_stim();
      rq[75] = 1'b1;
      for (int k = 85; k < MAXN; k++) lk[k] = 1'b1;
      run_scenario(120);

      // relock_req while in RUN.
      clear_stim();
      for (int k = 14; k < MAXN; k++) lk[k] = 1'b1;
      rq[30] = 1'b1;
      run_scenario(55);

      // Stops mid-WAIT_LOCK so the async reset lands there.
      clear_stim();
      run_scenario(10);

      for (int s = 0; s < 30; s++) begin
         clear_stim();
         gen_random(n);
         run_scenario(n);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
